// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift sequencer: FSM state encoding and shift directions.
// Encoding 2'd3 is unused; the FSM recovers from it to S_IDLE.
package shift_sequencer_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic SHIFT_LEFT  = 1'b0;
    localparam logic SHIFT_RIGHT = 1'b1;

endpackage

// File: rtl/shift_sequencer_shift.sv
// Single one-bit logical shift stage; the vacated bit is always filled with 0.
module one_bit_shift
    import shift_sequencer_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              dir,
    input  logic [DATA_W-1:0] d_in,
    output logic [DATA_W-1:0] d_out
);

    assign d_out = (dir == SHIFT_RIGHT) ? {1'b0, d_in[DATA_W-1:1]}
                                        : {d_in[DATA_W-2:0], 1'b0};

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: accepts one request, applies a one-bit shift per clock for
// shift_amt cycles, then holds the result until the consumer takes it.
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int AMT_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic              shift_lr,
    input  logic [AMT_W-1:0]  shift_amt,
    input  logic [DATA_W-1:0] shift_in,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [DATA_W-1:0] shift_out,
    output logic              busy
);

    state_t            r_state;
    logic [DATA_W-1:0] r_data;
    logic [AMT_W-1:0]  r_count;
    logic              r_dir;
    logic              r_start_ready;
    logic              r_result_valid;
    logic              r_busy;
    logic [DATA_W-1:0] w_shifted;

    one_bit_shift #(.DATA_W(DATA_W)) u_shift (
        .dir   (r_dir),
        .d_in  (r_data),
        .d_out (w_shifted)
    );

    // Status outputs are registered next to the state they decode, so no input
    // reaches an output combinationally.
    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_data         <= '0;
            r_count        <= '0;
            r_dir          <= SHIFT_LEFT;
            r_start_ready  <= 1'b1;
            r_result_valid <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_valid) begin
                        r_data        <= shift_in;
                        r_dir         <= shift_lr;
                        r_count       <= shift_amt;
                        r_start_ready <= 1'b0;
                        r_busy        <= 1'b1;
                        if (shift_amt == '0) begin
                            r_state        <= S_DONE;
                            r_result_valid <= 1'b1;
                        end else begin
                            r_state <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    r_data  <= w_shifted;
                    r_count <= r_count - AMT_W'(1);
                    if (r_count == AMT_W'(1)) begin
                        r_state        <= S_DONE;
                        r_result_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (result_ready) begin
                        r_state        <= S_IDLE;
                        r_result_valid <= 1'b0;
                        r_start_ready  <= 1'b1;
                        r_busy         <= 1'b0;
                    end
                end
                default: begin
                    r_state        <= S_IDLE;
                    r_result_valid <= 1'b0;
                    r_start_ready  <= 1'b1;
                    r_busy         <= 1'b0;
                end
            endcase
        end
    end

    assign start_ready  = r_start_ready;
    assign result_valid = r_result_valid;
    assign busy         = r_busy;
    assign shift_out    = r_data;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed cases plus a randomized sweep
// compared against a plain <<, >> reference model with latency tracking.
module tb_shift_sequencer;

    localparam int DATA_W = 32;
    localparam int AMT_W  = 5;
    localparam int MAX_WAIT = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_valid;
    logic              start_ready;
    logic              shift_lr;
    logic [AMT_W-1:0]  shift_amt;
    logic [DATA_W-1:0] shift_in;
    logic              result_valid;
    logic              result_ready;
    logic [DATA_W-1:0] shift_out;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;

    shift_sequencer #(.DATA_W(DATA_W), .AMT_W(AMT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .shift_lr     (shift_lr),
        .shift_amt    (shift_amt),
        .shift_in     (shift_in),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .shift_out    (shift_out),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] ref_shift(input logic [DATA_W-1:0] d,
                                                    input logic lr, input int amt);
        if (amt >= DATA_W) return '0;
        return lr ? (d >> amt) : (d << amt);
    endfunction

    // Entered and left at a falling edge with the DUT idle. Inputs are scrambled
    // while the request is in flight to show they are sampled only at accept.
    task automatic do_req(input logic [DATA_W-1:0] d, input logic lr,
                          input logic [AMT_W-1:0] amt, input int hold, input bit scramble);
        logic [DATA_W-1:0] exp;
        int n;
        exp = ref_shift(d, lr, int'(amt));
        check("ready_idle", 32'(start_ready), 32'd1);
        start_valid  = 1'b1;
        shift_in     = d;
        shift_lr     = lr;
        shift_amt    = amt;
        result_ready = (hold == 0);
        @(posedge clk);
        n = 0;
        while (n < MAX_WAIT) begin
            @(negedge clk);
            n++;
            if (result_valid) break;
            check("ready_busy", {30'd0, start_ready, busy}, 32'd1);
            if (scramble) begin
                start_valid = 1'($urandom);
                shift_in    = $urandom;
                shift_lr    = 1'($urandom);
                shift_amt   = AMT_W'($urandom);
            end else begin
                start_valid = 1'b0;
            end
        end
        start_valid = 1'b0;
        check("latency", 32'(n), 32'(int'(amt) + 1));
        check("result", shift_out, exp);
        check("done_ready", 32'(start_ready), 32'd0);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("hold_valid", 32'(result_valid), 32'd1);
            check("hold_data", shift_out, exp);
        end
        result_ready = 1'b1;
        @(negedge clk);
        check("done_one_cycle", {30'd0, result_valid, start_ready}, 32'd1);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int valid_seen;
        rst          = 1'b1;
        start_valid  = 1'b0;
        shift_lr     = 1'b0;
        shift_amt    = '0;
        shift_in     = '0;
        result_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(start_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(result_valid), 32'd0);
        check("rst_out", shift_out, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_req(32'h0000_0001, 1'b0, 5'd4, 0, 1'b0);
        do_req(32'h8000_0000, 1'b1, 5'd31, 0, 1'b1);
        do_req(32'hDEAD_BEEF, 1'b1, 5'd0, 0, 1'b0);
        do_req(32'hDEAD_BEEF, 1'b0, 5'd0, 0, 1'b0);
        do_req(32'hF0F0_1234, 1'b0, 5'd7, 10, 1'b1);
        do_req(32'hFFFF_FFFF, 1'b1, 5'd1, 0, 1'b1);

        // Abort a 20-cycle request in its 3rd SHIFT cycle.
        start_valid  = 1'b1;
        shift_in     = 32'hCAFE_F00D;
        shift_lr     = 1'b0;
        shift_amt    = 5'd20;
        result_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", 32'(start_ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_out", shift_out, 32'd0);
        valid_seen = 0;
        for (int k = 0; k < 30; k++) begin
            if (result_valid) valid_seen++;
            @(negedge clk);
        end
        check("abort_no_result", 32'(valid_seen), 32'd0);

        for (int i = 0; i < 500; i++) begin
            int hold;
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            do_req($urandom, 1'($urandom), AMT_W'($urandom), hold, 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
